cp0_reg: RTL
============

# cp0_reg

Coprocessor-0 register file for the five-stage MIPS pipeline. It holds Count, Compare, Status, Cause, EPC, PRId and Config and serves mfc0 reads and wb-stage mtc0 writes. It records exceptions from the mem stage and raises the timer interrupt. Its EPC output feeds the pipeline controller, which uses it as the eret return target.

## Interface
- No parameters.
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- we_i  input  1  mtc0 write enable (from wb stage)
- waddr_i  input  5  CP0 register number written
- raddr_i  input  5  CP0 register number read (mfc0, ex stage)
- data_i  input  32  mtc0 write data
- int_i  input  6  external hardware interrupt lines
- excepttype_i  input  32  exception code from mem stage (0 = none)
- current_inst_addr_i  input  32  PC of faulting instruction
- is_in_delayslot_i  input  1  faulting instruction is in a delay slot
- data_o  output  32  read data for raddr_i
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  output  32 each  register contents
- timer_int_o  output  1  timer interrupt request

## Operation
- Register numbers: Count 9, Compare 11, Status 12, Cause 13, EPC 14, PRId 15, Config 16.
- Reset values:
  - Count 0, Compare 0, Status 0x10000000 (CU0=1), Cause 0, EPC 0.
  - Config 0x00008000 (BE=1), PRId 0x004C0102.
  - timer_int_o 0.
- Every non-reset cycle:
  - Count increments by 1, wrapping 0xFFFFFFFF→0.
  - Cause[15:10] is loaded from int_i.
- Timer: when Compare ≠ 0 and Count == Compare, timer_int_o is set to 1 next cycle. It holds until an mtc0 write to Compare, which clears it.
- mtc0 (we_i=1):
  - Count: loaded with data_i. This replaces that cycle's increment.
  - Compare: loaded with data_i; clears timer_int_o.
  - Status: fully writable.
  - EPC: fully writable.
  - Cause: only IP[9:8], WP[22] and IV[23] are writable; other bits keep their value.
  - PRId, Config: read-only; writes ignored.
- Exception recording (excepttype_i ≠ 0):
  - 0x01 interrupt: EPC ← current_inst_addr_i, or current_inst_addr_i−4 if is_in_delayslot_i. Cause.BD[31] ← is_in_delayslot_i. Status.EXL[1] ← 1. Cause.ExcCode[6:2] ← 0. EPC/BD always update.
  - 0x08 syscall: ExcCode 8. EPC/BD update only if Status.EXL was 0; EXL ← 1.
  - 0x0A reserved instruction: ExcCode 10, same EXL-gated rule.
  - 0x0D trap: ExcCode 13, same rule.
  - 0x0C overflow: ExcCode 12, same rule.
  - 0x0F: ExcCode 15, same rule.
  - 0x0E eret: Status.EXL ← 0. No other change.
  - Any other nonzero code: no change.
- Simultaneous mtc0 and exception in the same cycle: the mtc0 write applies first, then exception fields override the overlapping bits (EPC, BD, EXL, ExcCode).
- Read path: data_o is combinational from raddr_i.
  - Unmapped register numbers read 0.
  - There is no internal bypass of a same-cycle write; the ex stage forwards it.

## Timing
- All register updates are visible on outputs one cycle after the triggering edge.
- Reads have zero latency (combinational).
- timer_int_o asserts exactly one cycle after the cycle in which Count == Compare.
- rst asserted mid-operation restores every reset value on the next edge, including a pending timer_int_o. An exception presented in the same cycle is discarded.
- Count runs continuously whenever rst is 0. It is not affected by pipeline stall or flush.

## Configuration
- CP0_TIMER_EN defined: Count/Compare behave as above and timer_int_o is driven.
- CP0_TIMER_EN undefined:
  - Count and Compare are removed.
  - count_o, compare_o and reads of registers 9/11 return 0.
  - Writes to 9/11 are ignored.
  - timer_int_o is tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Reset then idle 5 cycles → Count=5, Status=0x10000000, PRId=0x004C0102, timer_int_o=0.
- mtc0 Compare=0x20 at Count≈0x10 → timer_int_o=1 one cycle after Count=0x20. A later mtc0 Compare=0x100 → timer_int_o=0 next cycle.
- excepttype_i=0x08, current_inst_addr_i=0x1000, delayslot=0, EXL=0 → EPC=0x1000, ExcCode=8, EXL=1, BD=0. Then excepttype_i=0x0E → EXL=0, EPC still 0x1000.
- excepttype_i=0x01, addr=0x2004, delayslot=1 → EPC=0x2000, BD=1, ExcCode=0. A second syscall while EXL=1 → EPC unchanged, ExcCode=8.
- Same cycle: mtc0 EPC=0xAAAA with excepttype_i=0x0C at addr 0x3000 → EPC=0x3000, ExcCode=12. mtc0 Cause=0xFFFFFFFF alone → only bits 23,22,9,8 set; Cause[15:10] tracks int_i=0x2A.
- Count write 0xFFFFFFFF → reads 0 the following cycle. Without CP0_TIMER_EN → register 9 reads 0 and timer_int_o stays 0.

Source files
------------

// File: rtl/cp0_reg.sv
// CP0 register file: Count/Compare timer, Status, Cause, EPC, PRId, Config.
// Define CP0_TIMER_EN to build Count/Compare and the timer interrupt.
module cp0_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;

  localparam logic [31:0] STATUS_RST = 32'h1000_0000;
  localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;
  localparam logic [31:0] PRID_VAL   = 32'h004C_0102;

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] exc_epc;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_int_q, timer_int_d;

  // A Compare write wins over a same-cycle match so software can always ack.
  always_comb begin
    count_d     = count_q + 32'd1;
    compare_d   = compare_q;
    timer_int_d = timer_int_q;
    if (compare_q != 32'd0 && count_q == compare_q) timer_int_d = 1'b1;
    if (we_i && waddr_i == REG_COUNT) count_d = data_i;
    if (we_i && waddr_i == REG_COMPARE) begin
      compare_d   = data_i;
      timer_int_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      compare_q   <= '0;
      timer_int_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;
`else
  assign count_o     = '0;
  assign compare_o   = '0;
  assign timer_int_o = 1'b0;
`endif

  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    exc_epc  = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
    cause_d[15:10] = int_i;
    if (we_i) begin
      case (waddr_i)
        REG_STATUS: status_d = data_i;
        REG_EPC:    epc_d    = data_i;
        REG_CAUSE: begin
          cause_d[9:8]   = data_i[9:8];
          cause_d[23:22] = data_i[23:22];
        end
        default: ;
      endcase
    end
    // Exception fields land after the mtc0 so they override overlapping bits.
    case (excepttype_i)
      32'h01: begin
        epc_d         = exc_epc;
        cause_d[31]   = is_in_delayslot_i;
        status_d[1]   = 1'b1;
        cause_d[6:2]  = 5'd0;
      end
      32'h08, 32'h0A, 32'h0C, 32'h0D, 32'h0F: begin
        if (!status_q[1]) begin
          epc_d       = exc_epc;
          cause_d[31] = is_in_delayslot_i;
        end
        status_d[1]  = 1'b1;
        cause_d[6:2] = excepttype_i[4:0];
      end
      32'h0E: status_d[1] = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RST;
      cause_q  <= '0;
      epc_q    <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
    end
  end

  assign status_o = status_q;
  assign cause_o  = cause_q;
  assign epc_o    = epc_q;
  assign config_o = CONFIG_VAL;
  assign prid_o   = PRID_VAL;

  always_comb begin
    data_o = '0;
    case (raddr_i)
      REG_COUNT:   data_o = count_o;
      REG_COMPARE: data_o = compare_o;
      REG_STATUS:  data_o = status_q;
      REG_CAUSE:   data_o = cause_q;
      REG_EPC:     data_o = epc_q;
      REG_PRID:    data_o = PRID_VAL;
      REG_CONFIG:  data_o = CONFIG_VAL;
      default:     data_o = '0;
    endcase
  end
endmodule
